// File: rtl/mc_sequencer_pkg.sv
// Shared MIPS multicycle definitions: state encoding, opcodes, ALUop codes,
// pc_src / reg_dst / err_code encodings and the opcode legality check.
package mc_sequencer_pkg;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b000010;
   localparam logic [5:0] OP_SUBI  = 6'b000011;
   localparam logic [5:0] OP_ANDI  = 6'b000100;
   localparam logic [5:0] OP_ORI   = 6'b000101;
   localparam logic [5:0] OP_SLTI  = 6'b000111;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_LB    = 6'b001001;
   localparam logic [5:0] OP_SW    = 6'b010000;
   localparam logic [5:0] OP_SB    = 6'b010001;
   localparam logic [5:0] OP_BEQ   = 6'b100011;
   localparam logic [5:0] OP_BNE   = 6'b100111;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JAL   = 6'b111001;
   localparam logic [5:0] OP_MOVE  = 6'b100000;

   localparam logic [2:0] ALU_NONE  = 3'd0;
   localparam logic [2:0] ALU_ADD   = 3'd1;
   localparam logic [2:0] ALU_SUB   = 3'd2;
   localparam logic [2:0] ALU_AND   = 3'd3;
   localparam logic [2:0] ALU_OR    = 3'd4;
   localparam logic [2:0] ALU_LESS  = 3'd5;
   localparam logic [2:0] ALU_RTYPE = 3'd6;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   function automatic logic is_legal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI,
         OP_LW, OP_LB, OP_SW, OP_SB, OP_BEQ, OP_BNE,
         OP_J, OP_JAL, OP_MOVE: return 1'b1;
         default:               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_sequencer_wait_timer.sv
// Memory-ack wait counter. expired is high while the count equals ACK_TIMEOUT,
// i.e. after ACK_TIMEOUT wait cycles; an ack in that cycle still completes.
module mc_wait_timer #(
   parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   logic [7:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        cnt <= '0;
      else if (clear)    cnt <= '0;
      else if (count_en) cnt <= cnt + 8'd1;
   end

   assign expired = (cnt == ACK_TIMEOUT);

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with a TRAP
// state for illegal opcodes and memory timeouts. ACK_TIMEOUT must be 1..255.
module mc_sequencer
   import mc_sequencer_pkg::*;
#(
   parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       byte_en,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] pc_src,
   output logic [1:0] reg_dst,
   output logic       alu_src,
   output logic [2:0] alu_op,
   output logic       halted,
   output logic [1:0] err_code
);

   logic [2:0] state, state_nx;
   logic [5:0] op_q;
   logic [1:0] err_q, err_nx;
   logic       timeout;
   logic       is_load;

   assign is_load = (op_q == OP_LW) || (op_q == OP_LB);

   // Clearing on every state change keeps the count at zero on entry to FETCH/MEM.
   mc_wait_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_wait_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (state_nx != state),
      .count_en (mem_req && !mem_ack),
      .expired  (timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FETCH;
         op_q  <= '0;
         err_q <= ERR_NONE;
      end else begin
         state <= state_nx;
         err_q <= err_nx;
         if (state == ST_DECODE) op_q <= opcode;
      end
   end

   always_comb begin
      state_nx = state;
      err_nx   = err_q;
      case (state)
         ST_FETCH: begin
            if (mem_ack) state_nx = ST_DECODE;
            else if (timeout) begin
               state_nx = ST_TRAP;
               err_nx   = ERR_TIMEOUT;
            end
         end
         ST_DECODE: begin
            if (is_legal(opcode)) state_nx = ST_EXEC;
            else begin
               state_nx = ST_TRAP;
               err_nx   = ERR_ILLEGAL;
            end
         end
         ST_EXEC: begin
            case (op_q)
               OP_RTYPE, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI,
               OP_MOVE:                     state_nx = ST_WB;
               OP_LW, OP_LB, OP_SW, OP_SB:  state_nx = ST_MEM;
               default:                     state_nx = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            if (mem_ack) state_nx = is_load ? ST_WB : ST_FETCH;
            else if (timeout) begin
               state_nx = ST_TRAP;
               err_nx   = ERR_TIMEOUT;
            end
         end
         ST_WB:   state_nx = ST_FETCH;
         ST_TRAP: state_nx = ST_TRAP;
         default: state_nx = ST_FETCH;
      endcase
   end

   // Everything is held at zero while rst_n is low, even though state reads FETCH.
   always_comb begin
      mem_req   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = 1'b0;
      byte_en   = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      pc_src    = PC_SEQ;
      reg_dst   = RD_RT;
      alu_src   = 1'b0;
      alu_op    = ALU_NONE;
      halted    = 1'b0;
      if (rst_n) begin
         case (state)
            ST_FETCH: begin
               mem_req  = 1'b1;
               mem_read = 1'b1;
               ir_write = mem_ack;
               pc_write = mem_ack;
            end
            ST_DECODE: begin
               alu_op  = ALU_ADD;
               alu_src = 1'b1;
            end
            ST_EXEC: begin
               case (op_q)
                  OP_RTYPE: alu_op = ALU_RTYPE;
                  OP_ADDI:  begin alu_op = ALU_ADD;  alu_src = 1'b1; end
                  OP_SUBI:  begin alu_op = ALU_SUB;  alu_src = 1'b1; end
                  OP_ANDI:  begin alu_op = ALU_AND;  alu_src = 1'b1; end
                  OP_ORI:   begin alu_op = ALU_OR;   alu_src = 1'b1; end
                  OP_SLTI:  begin alu_op = ALU_LESS; alu_src = 1'b1; end
                  OP_MOVE:  alu_op = ALU_ADD;
                  OP_LW, OP_LB, OP_SW, OP_SB: begin
                     alu_op  = ALU_ADD;
                     alu_src = 1'b1;
                  end
                  OP_BEQ, OP_BNE: begin
                     alu_op   = ALU_SUB;
                     pc_write = (op_q == OP_BEQ) ? zero : !zero;
                     pc_src   = pc_write ? PC_BRANCH : PC_SEQ;
                  end
                  OP_J: begin
                     pc_write = 1'b1;
                     pc_src   = PC_JUMP;
                  end
                  OP_JAL: begin
                     pc_write  = 1'b1;
                     pc_src    = PC_JUMP;
                     reg_write = 1'b1;
                     reg_dst   = RD_RA;
                  end
                  default: ;
               endcase
            end
            ST_MEM: begin
               mem_req   = 1'b1;
               iord      = 1'b1;
               mem_read  = is_load;
               mem_write = !is_load;
               byte_en   = (op_q == OP_LB) || (op_q == OP_SB);
            end
            ST_WB: begin
               reg_write = 1'b1;
               reg_dst   = (op_q == OP_RTYPE) ? RD_RD : RD_RT;
            end
            ST_TRAP: halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign err_code = err_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: stimulus pushes the expected output vector
// for each cycle; an independent monitor pops and compares on every falling edge.
module tb_mc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ack = 1'b0;
   logic       mem_req, mem_read, mem_write, iord, byte_en;
   logic       ir_write, pc_write, reg_write, alu_src, halted;
   logic [1:0] pc_src, reg_dst, err_code;
   logic [2:0] alu_op;

   localparam logic [2:0] A_NONE = 3'd0, A_ADD = 3'd1, A_SUB = 3'd2, A_AND = 3'd3,
                          A_OR = 3'd4, A_LESS = 3'd5, A_RTYPE = 3'd6;

   mc_sequencer #(.ACK_TIMEOUT(8'd4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .opcode    (opcode),
      .zero      (zero),
      .mem_ack   (mem_ack),
      .mem_req   (mem_req),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .iord      (iord),
      .byte_en   (byte_en),
      .ir_write  (ir_write),
      .pc_write  (pc_write),
      .reg_write (reg_write),
      .pc_src    (pc_src),
      .reg_dst   (reg_dst),
      .alu_src   (alu_src),
      .alu_op    (alu_op),
      .halted    (halted),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mem_req, mem_read, mem_write, iord, byte_en;
      logic       ir_write, pc_write, reg_write;
      logic [1:0] pc_src, reg_dst;
      logic       alu_src;
      logic [2:0] alu_op;
      logic       halted;
      logic [1:0] err_code;
   } vec_t;

   typedef struct {
      vec_t  v;
      string tag;
   } exp_t;

   exp_t        expq[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   vec_t        act;

   assign act = {mem_req, mem_read, mem_write, iord, byte_en, ir_write, pc_write,
                 reg_write, pc_src, reg_dst, alu_src, alu_op, halted, err_code};

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if (act !== e.v) begin
               n_bad++;
               $display("FAIL %s @%0t: got %05h expected %05h", e.tag, $time, act, e.v);
            end
         end
      end
   end

   function automatic vec_t f_fetch(input logic ack);
      vec_t v = '0;
      v.mem_req = 1'b1; v.mem_read = 1'b1; v.ir_write = ack; v.pc_write = ack;
      return v;
   endfunction

   function automatic vec_t f_decode();
      vec_t v = '0;
      v.alu_op = A_ADD; v.alu_src = 1'b1;
      return v;
   endfunction

   function automatic vec_t f_exec(input logic [2:0] aop, input logic asrc, input logic pcw,
                                   input logic [1:0] pcs, input logic rw, input logic [1:0] rd);
      vec_t v = '0;
      v.alu_op = aop; v.alu_src = asrc; v.pc_write = pcw; v.pc_src = pcs;
      v.reg_write = rw; v.reg_dst = rd;
      return v;
   endfunction

   function automatic vec_t f_mem(input logic load, input logic bytes);
      vec_t v = '0;
      v.mem_req = 1'b1; v.iord = 1'b1; v.mem_read = load; v.mem_write = !load; v.byte_en = bytes;
      return v;
   endfunction

   function automatic vec_t f_wb(input logic [1:0] rd);
      vec_t v = '0;
      v.reg_write = 1'b1; v.reg_dst = rd;
      return v;
   endfunction

   function automatic vec_t f_trap(input logic [1:0] err);
      vec_t v = '0;
      v.halted = 1'b1; v.err_code = err;
      return v;
   endfunction

   task automatic cyc(input logic ack, input vec_t v, input string tag);
      exp_t e;
      mem_ack = ack;
      e.v = v;
      e.tag = tag;
      expq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // opcode carries junk outside DECODE so the latched copy is what gets exercised
   task automatic fetch_decode(input int unsigned waits, input logic [5:0] op);
      opcode = ~op;
      for (int unsigned i = 0; i < waits; i++) cyc(1'b0, f_fetch(1'b0), "fetch_wait");
      cyc(1'b1, f_fetch(1'b1), "fetch_ack");
      opcode = op;
      cyc(1'b0, f_decode(), "decode");
      opcode = ~op;
   endtask

   task automatic run_alu(input logic [5:0] op, input logic [2:0] aop, input logic asrc,
                          input logic [1:0] rd, input int unsigned fw, input string tag);
      fetch_decode(fw, op);
      cyc(1'b0, f_exec(aop, asrc, 1'b0, 2'b00, 1'b0, 2'b00), {tag, "_exec"});
      cyc(1'b0, f_wb(rd), {tag, "_wb"});
   endtask

   task automatic run_mem(input logic [5:0] op, input logic load, input logic bytes,
                          input int unsigned mw, input string tag);
      fetch_decode(0, op);
      cyc(1'b0, f_exec(A_ADD, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00), {tag, "_exec"});
      for (int unsigned i = 0; i < mw; i++) cyc(1'b0, f_mem(load, bytes), {tag, "_mem_wait"});
      cyc(1'b1, f_mem(load, bytes), {tag, "_mem_ack"});
      if (load) cyc(1'b0, f_wb(2'b00), {tag, "_wb"});
   endtask

   task automatic run_br(input logic [5:0] op, input logic z, input logic taken, input string tag);
      fetch_decode(0, op);
      zero = z;
      cyc(1'b0, f_exec(A_SUB, 1'b0, taken, taken ? 2'b01 : 2'b00, 1'b0, 2'b00), {tag, "_exec"});
      zero = ~z;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      cyc(1'b1, '0, {tag, "_rst"});
      rst_n = 1'b1;
   endtask

   initial begin : stimulus
      @(posedge clk);
      #1;
      cyc(1'b0, '0, "reset0");
      cyc(1'b1, '0, "reset1");
      rst_n = 1'b1;

      run_alu(6'b000010, A_ADD,   1'b1, 2'b00, 0, "addi");
      run_alu(6'b000000, A_RTYPE, 1'b0, 2'b01, 1, "rtype");
      run_alu(6'b000011, A_SUB,   1'b1, 2'b00, 0, "subi");
      run_alu(6'b000100, A_AND,   1'b1, 2'b00, 0, "andi");
      run_alu(6'b000101, A_OR,    1'b1, 2'b00, 2, "ori");
      run_alu(6'b000111, A_LESS,  1'b1, 2'b00, 0, "slti");
      run_alu(6'b100000, A_ADD,   1'b0, 2'b00, 0, "move");

      run_mem(6'b001000, 1'b1, 1'b0, 0, "lw");
      run_mem(6'b001001, 1'b1, 1'b1, 3, "lb");
      run_mem(6'b010000, 1'b0, 1'b0, 1, "sw");
      run_mem(6'b010001, 1'b0, 1'b1, 0, "sb");

      run_br(6'b100011, 1'b1, 1'b1, "beq_z1");
      run_br(6'b100011, 1'b0, 1'b0, "beq_z0");
      run_br(6'b100111, 1'b0, 1'b1, "bne_z0");
      run_br(6'b100111, 1'b1, 1'b0, "bne_z1");

      // J fetched with ack arriving exactly at the timeout count
      fetch_decode(4, 6'b111000);
      cyc(1'b0, f_exec(A_NONE, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00), "j_exec");
      fetch_decode(0, 6'b111001);
      cyc(1'b0, f_exec(A_NONE, 1'b0, 1'b1, 2'b10, 1'b1, 2'b10), "jal_exec");

      run_mem(6'b010000, 1'b0, 1'b0, 4, "sw_limit");

      // reset during a MEM wait
      fetch_decode(0, 6'b001000);
      cyc(1'b0, f_exec(A_ADD, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00), "lwrst_exec");
      cyc(1'b0, f_mem(1'b1, 1'b0), "lwrst_mem_wait");
      rst_n = 1'b0;
      cyc(1'b0, '0, "lwrst_in_reset");
      cyc(1'b1, '0, "lwrst_hold");
      rst_n = 1'b1;
      run_alu(6'b000010, A_ADD, 1'b1, 2'b00, 1, "addi_after_rst");

      fetch_decode(0, 6'b111111);
      for (int unsigned i = 0; i < 3; i++) cyc(1'b1, f_trap(2'b01), "trap_illegal");
      do_reset("illegal");

      for (int unsigned i = 0; i < 5; i++) cyc(1'b0, f_fetch(1'b0), "fetch_to_wait");
      for (int unsigned i = 0; i < 2; i++) cyc(1'b1, f_trap(2'b10), "trap_fetch_to");
      do_reset("fetch_to");

      fetch_decode(0, 6'b001001);
      cyc(1'b0, f_exec(A_ADD, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00), "lbto_exec");
      for (int unsigned i = 0; i < 5; i++) cyc(1'b0, f_mem(1'b1, 1'b1), "lbto_mem_wait");
      for (int unsigned i = 0; i < 2; i++) cyc(1'b0, f_trap(2'b10), "trap_mem_to");

      @(negedge clk);
      #1;
      if (expq.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
